// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction-decode stage for the pipelined
// LEGv8-subset CPU. Sits between the IF/ID register and execute.
//
// Each accepted instruction is decoded into a control/operand bundle and held in an
// output register. A load-use scoreboard inserts bubbles while a dependent
// instruction waits for a load result still inside the downstream load shadow.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   in_valid_i / in_ready_o upstream handshake, instr_i is the instruction word
//   flush_i                 kill the output register and clear the scoreboard
//   out_valid_o/out_ready_i downstream handshake for the bundle below
//   reg_write_o .. illegal_o registered control bits
//   alu_op_o                000 pass-B, 010 add, 011 sub
//   rn_o, rm_o, rd_o        register indices (31 when unused)
//   imm_o                   sign-/zero-extended word-offset immediate
module decode_stage #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned LOAD_SHADOW = 1,
    parameter int unsigned ZERO_REG    = 31
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              mem_to_reg_o,
    output logic              alu_src_o,
    output logic              set_flags_o,
    output logic              uncond_br_o,
    output logic              cond_br_o,
    output logic              cbz_o,
    output logic              br_reg_o,
    output logic              bl_o,
    output logic              illegal_o,
    output logic [2:0]        alu_op_o,
    output logic [4:0]        rn_o,
    output logic [4:0]        rm_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] imm_o
);

    localparam logic [4:0] NoReg   = 5'd31;
    localparam logic [4:0] ZeroIdx = 5'(ZERO_REG);
    localparam logic [4:0] LinkReg = 5'd30;

    localparam logic [2:0] AluPassB = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b010;
    localparam logic [2:0] AluSub   = 3'b011;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              set_flags;
        logic              uncond_br;
        logic              cond_br;
        logic              cbz;
        logic              br_reg;
        logic              bl;
        logic              illegal;
        logic [2:0]        alu_op;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [4:0]        rd;
        logic [DATA_W-1:0] imm;
    } bundle_t;

    // Bundle value used for reset, bubbles and flushes: no side effects downstream.
    localparam bundle_t IdleBundle = '{
        alu_op:  AluPassB,
        rn:      NoReg,
        rm:      NoReg,
        rd:      NoReg,
        default: '0
    };

    bundle_t dec;
    logic    use_rn;
    logic    use_rm;
    logic    is_load;

    bundle_t bundle_d, bundle_q;
    logic    out_valid_d, out_valid_q;

    logic [LOAD_SHADOW-1:0] sb_valid_d, sb_valid_q;
    logic [4:0]             sb_rd_d [LOAD_SHADOW];
    logic [4:0]             sb_rd_q [LOAD_SHADOW];

    logic hit;
    logic stall;
    logic advance;
    logic accept;

    // ------------------------------------------------------------------
    // Combinational decode of the presented instruction
    // ------------------------------------------------------------------
    always_comb begin
        dec     = IdleBundle;
        use_rn  = 1'b0;
        use_rm  = 1'b0;
        is_load = 1'b0;

        if (instr_i[31:22] == 10'b1001000100) begin          // ADDI
            dec.rn        = instr_i[9:5];
            dec.rd        = instr_i[4:0];
            dec.imm       = {{(DATA_W-12){1'b0}}, instr_i[21:10]};
            dec.alu_src   = 1'b1;
            dec.alu_op    = AluAdd;
            dec.reg_write = 1'b1;
            use_rn        = 1'b1;
        end else if (instr_i[31:21] == 11'b10101011000 ||     // ADDS
                     instr_i[31:21] == 11'b11101011000) begin // SUBS
            dec.rn        = instr_i[9:5];
            dec.rm        = instr_i[20:16];
            dec.rd        = instr_i[4:0];
            dec.alu_op    = instr_i[30] ? AluSub : AluAdd;
            dec.set_flags = 1'b1;
            dec.reg_write = 1'b1;
            use_rn        = 1'b1;
            use_rm        = 1'b1;
        end else if (instr_i[31:21] == 11'b11111000010) begin // LDUR
            dec.rn         = instr_i[9:5];
            dec.rd         = instr_i[4:0];
            dec.imm        = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
            dec.alu_src    = 1'b1;
            dec.alu_op     = AluAdd;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            use_rn         = 1'b1;
            is_load        = 1'b1;
        end else if (instr_i[31:21] == 11'b11111000000) begin // STUR
            dec.rn        = instr_i[9:5];
            dec.rm        = instr_i[4:0];                     // store data
            dec.imm       = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
            dec.alu_src   = 1'b1;
            dec.alu_op    = AluAdd;
            dec.mem_write = 1'b1;
            use_rn        = 1'b1;
            use_rm        = 1'b1;
        end else if (instr_i[30:26] == 5'b00101) begin        // B / BL (bit 31 selects BL)
            dec.imm       = {{(DATA_W-26){instr_i[25]}}, instr_i[25:0]};
            dec.uncond_br = 1'b1;
            if (instr_i[31]) begin
                dec.bl        = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = LinkReg;
            end
        end else if (instr_i[31:24] == 8'b01010100) begin     // B.cond
            dec.imm     = {{(DATA_W-19){instr_i[23]}}, instr_i[23:5]};
            dec.cond_br = 1'b1;
            dec.rd      = instr_i[4:0];                       // condition code
        end else if (instr_i[31:24] == 8'b10110100) begin     // CBZ
            dec.imm    = {{(DATA_W-19){instr_i[23]}}, instr_i[23:5]};
            dec.cbz    = 1'b1;
            dec.rm     = instr_i[4:0];
            use_rm     = 1'b1;
        end else if (instr_i[31:21] == 11'b11010110000) begin // BR
            dec.br_reg = 1'b1;
            dec.rn     = instr_i[9:5];
            use_rn     = 1'b1;
        end else begin
            dec.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard detection against the scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < LOAD_SHADOW; i++) begin
            if (sb_valid_q[i]) begin
                if (use_rn && dec.rn != ZeroIdx && dec.rn == sb_rd_q[i]) hit = 1'b1;
                if (use_rm && dec.rm != ZeroIdx && dec.rm == sb_rd_q[i]) hit = 1'b1;
            end
        end
    end

    assign stall      = in_valid_i & hit;
    assign advance    = out_ready_i | ~out_valid_q;
    assign in_ready_o = advance & ~stall & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    // ------------------------------------------------------------------
    // Next-state: output register and scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        sb_valid_d  = sb_valid_q;
        sb_rd_d     = sb_rd_q;

        if (flush_i) begin
            bundle_d    = IdleBundle;
            out_valid_d = 1'b0;
            sb_valid_d  = '0;
        end else if (advance) begin
            bundle_d    = accept ? dec : IdleBundle;
            out_valid_d = accept;
            // Age every entry by one stage; entry 0 takes the load just accepted.
            for (int unsigned i = 1; i < LOAD_SHADOW; i++) begin
                sb_valid_d[i] = sb_valid_q[i-1];
                sb_rd_d[i]    = sb_rd_q[i-1];
            end
            sb_valid_d[0] = accept & is_load & (dec.rd != ZeroIdx);
            sb_rd_d[0]    = dec.rd;
        end
        // Held output (out_valid & ~out_ready): everything keeps its value.
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bundle_q    <= IdleBundle;
            out_valid_q <= 1'b0;
            sb_valid_q  <= '0;
            for (int unsigned i = 0; i < LOAD_SHADOW; i++) begin
                sb_rd_q[i] <= NoReg;
            end
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            sb_valid_q  <= sb_valid_d;
            sb_rd_q     <= sb_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid_o  = out_valid_q;
    assign reg_write_o  = bundle_q.reg_write;
    assign mem_write_o  = bundle_q.mem_write;
    assign mem_to_reg_o = bundle_q.mem_to_reg;
    assign alu_src_o    = bundle_q.alu_src;
    assign set_flags_o  = bundle_q.set_flags;
    assign uncond_br_o  = bundle_q.uncond_br;
    assign cond_br_o    = bundle_q.cond_br;
    assign cbz_o        = bundle_q.cbz;
    assign br_reg_o     = bundle_q.br_reg;
    assign bl_o         = bundle_q.bl;
    assign illegal_o    = bundle_q.illegal;
    assign alu_op_o     = bundle_q.alu_op;
    assign rn_o         = bundle_q.rn;
    assign rm_o         = bundle_q.rm;
    assign rd_o         = bundle_q.rd;
    assign imm_o        = bundle_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage. Two instances share all inputs: u_dut1 with
// LOAD_SHADOW=1 and u_dut2 with LOAD_SHADOW=2. Expected values are hand-decoded.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;

    always #5 clk = ~clk;

    // Control bit positions in the packed ctrl vectors below.
    localparam logic [10:0] C_RW  = 11'h400;
    localparam logic [10:0] C_MW  = 11'h200;
    localparam logic [10:0] C_MR  = 11'h100;
    localparam logic [10:0] C_AS  = 11'h080;
    localparam logic [10:0] C_SF  = 11'h040;
    localparam logic [10:0] C_UB  = 11'h020;
    localparam logic [10:0] C_CB  = 11'h010;
    localparam logic [10:0] C_CZ  = 11'h008;
    localparam logic [10:0] C_BR  = 11'h004;
    localparam logic [10:0] C_BL  = 11'h002;
    localparam logic [10:0] C_IL  = 11'h001;

    localparam logic [31:0] I_ADDI = 32'h9100_1441; // ADDI X1,X2,#5
    localparam logic [31:0] I_LDUR = 32'hF85F_8023; // LDUR X3,[X1,#-8]
    localparam logic [31:0] I_ADDS = 32'hAB05_0064; // ADDS X4,X3,X5
    localparam logic [31:0] I_B    = 32'h17FF_FFFF; // B -1
    localparam logic [31:0] I_BL   = 32'h9400_0004; // BL +4
    localparam logic [31:0] I_CBZ  = 32'hB400_0065; // CBZ X5,+3

    localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    // DUT 1 outputs
    logic       ir1, ov1;
    logic       rw1, mw1, mr1, as1, sf1, ub1, cb1, cz1, br1, bl1, il1;
    logic [2:0] aop1;
    logic [4:0] rn1, rm1, rd1;
    logic [63:0] imm1;
    // DUT 2 outputs
    logic       ir2, ov2;
    logic       rw2, mw2, mr2, as2, sf2, ub2, cb2, cz2, br2, bl2, il2;
    logic [2:0] aop2;
    logic [4:0] rn2, rm2, rd2;
    logic [63:0] imm2;

    logic [10:0] ctrl1, ctrl2;
    assign ctrl1 = {rw1, mw1, mr1, as1, sf1, ub1, cb1, cz1, br1, bl1, il1};
    assign ctrl2 = {rw2, mw2, mr2, as2, sf2, ub2, cb2, cz2, br2, bl2, il2};

    decode_stage #(.DATA_W(64), .LOAD_SHADOW(1), .ZERO_REG(31)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(ir1),
        .instr_i(instr), .flush_i(flush), .out_valid_o(ov1), .out_ready_i(out_ready),
        .reg_write_o(rw1), .mem_write_o(mw1), .mem_to_reg_o(mr1), .alu_src_o(as1),
        .set_flags_o(sf1), .uncond_br_o(ub1), .cond_br_o(cb1), .cbz_o(cz1),
        .br_reg_o(br1), .bl_o(bl1), .illegal_o(il1), .alu_op_o(aop1),
        .rn_o(rn1), .rm_o(rm1), .rd_o(rd1), .imm_o(imm1)
    );

    decode_stage #(.DATA_W(64), .LOAD_SHADOW(2), .ZERO_REG(31)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(ir2),
        .instr_i(instr), .flush_i(flush), .out_valid_o(ov2), .out_ready_i(out_ready),
        .reg_write_o(rw2), .mem_write_o(mw2), .mem_to_reg_o(mr2), .alu_src_o(as2),
        .set_flags_o(sf2), .uncond_br_o(ub2), .cond_br_o(cb2), .cbz_o(cz2),
        .br_reg_o(br2), .bl_o(bl2), .illegal_o(il2), .alu_op_o(aop2),
        .rn_o(rn2), .rm_o(rm2), .rd_o(rd2), .imm_o(imm2)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check the full bundle of DUT 1; alu_op and imm only where they are defined.
    task automatic check_bundle1(input string tag, input logic v, input logic [10:0] c,
                                 input logic [2:0] aop, input logic chk_aop,
                                 input logic [4:0] rn, input logic [4:0] rm,
                                 input logic [4:0] rd, input logic [63:0] imm,
                                 input logic chk_imm);
        check_val({tag, ".valid"}, 64'(ov1), 64'(v));
        check_val({tag, ".ctrl"}, 64'(ctrl1), 64'(c));
        if (chk_aop) check_val({tag, ".alu_op"}, 64'(aop1), 64'(aop));
        check_val({tag, ".rn"}, 64'(rn1), 64'(rn));
        check_val({tag, ".rm"}, 64'(rm1), 64'(rm));
        check_val({tag, ".rd"}, 64'(rd1), 64'(rd));
        if (chk_imm) check_val({tag, ".imm"}, imm1, imm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [10:0] ctrl;
        logic [2:0]  aop;
        logic        chk_aop;
        logic [4:0]  rn, rm, rd;
        logic [63:0] imm;
        logic        chk_imm;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{32'hEB02_0020, C_RW | C_SF, 3'b011, 1'b1, 5'd1, 5'd2, 5'd0, 64'd0, 1'b0}; // SUBS
        tbl[1] = '{32'hF81F_8022, C_MW | C_AS, 3'b000, 1'b0, 5'd1, 5'd2, 5'd31, M8, 1'b1};   // STUR
        tbl[2] = '{32'h54FF_FFEB, C_CB, 3'b000, 1'b0, 5'd31, 5'd31, 5'd11, M1, 1'b1};        // B.cond
        tbl[3] = '{32'h5400_0041, C_CB, 3'b000, 1'b0, 5'd31, 5'd31, 5'd1, 64'd2, 1'b1};      // B.cond
        tbl[4] = '{32'hD61F_0060, C_BR, 3'b000, 1'b0, 5'd3, 5'd31, 5'd31, 64'd0, 1'b0};      // BR X3
        tbl[5] = '{32'h0000_0000, C_IL, 3'b000, 1'b1, 5'd31, 5'd31, 5'd31, 64'd0, 1'b1};     // illegal
        tbl[6] = '{32'h913F_FC00, C_RW | C_AS, 3'b010, 1'b1, 5'd0, 5'd31, 5'd0, 64'd4095, 1'b1}; // ADDI
        tbl[7] = '{32'hF860_0000, C_IL, 3'b000, 1'b1, 5'd31, 5'd31, 5'd31, 64'd0, 1'b1};     // illegal

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0;
        tick(); tick();
        check_bundle1("reset", 1'b0, 11'd0, 3'b000, 1'b1, 5'd31, 5'd31, 5'd31, 64'd0, 1'b1);
        reset = 1'b0;

        // Basic stream with a LOAD_SHADOW=1 load-use bubble.
        in_valid = 1'b1; instr = I_ADDI; #1;
        check_val("addi.in_ready", 64'(ir1), 64'd1);
        tick();
        check_bundle1("addi", 1'b1, C_RW | C_AS, 3'b010, 1'b1, 5'd2, 5'd31, 5'd1, 64'd5, 1'b1);
        instr = I_LDUR;
        tick();
        check_bundle1("ldur", 1'b1, C_RW | C_MR | C_AS, 3'b000, 1'b0, 5'd1, 5'd31, 5'd3, M8, 1'b1);
        instr = I_ADDS; #1;
        check_val("ls1.stall.in_ready", 64'(ir1), 64'd0);
        tick();
        check_val("ls1.bubble.valid", 64'(ov1), 64'd0);
        check_val("ls1.after.in_ready", 64'(ir1), 64'd1);
        tick();
        check_bundle1("adds", 1'b1, C_RW | C_SF, 3'b010, 1'b1, 5'd3, 5'd5, 5'd4, 64'd0, 1'b0);
        instr = I_B;
        tick();
        check_bundle1("b", 1'b1, C_UB, 3'b000, 1'b0, 5'd31, 5'd31, 5'd31, M1, 1'b1);
        instr = I_BL;
        tick();
        check_bundle1("bl", 1'b1, C_RW | C_BL | C_UB, 3'b000, 1'b0, 5'd31, 5'd31, 5'd30,
                      64'd4, 1'b1);

        // Hold the BL bundle for three cycles.
        out_ready = 1'b0; instr = I_CBZ; #1;
        check_val("hold.in_ready", 64'(ir1), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bundle1("hold", 1'b1, C_RW | C_BL | C_UB, 3'b000, 1'b0, 5'd31, 5'd31, 5'd30,
                          64'd4, 1'b1);
            check_val("hold.in_ready", 64'(ir1), 64'd0);
        end
        out_ready = 1'b1; #1;
        check_val("release.in_ready", 64'(ir1), 64'd1);
        tick();
        check_bundle1("cbz", 1'b1, C_CZ, 3'b000, 1'b1, 5'd31, 5'd5, 5'd31, 64'd3, 1'b1);

        // Back-to-back table of further encodings.
        for (int i = 0; i < 8; i++) begin
            instr = tbl[i].ins;
            tick();
            check_bundle1($sformatf("tbl%0d", i), 1'b1, tbl[i].ctrl, tbl[i].aop, tbl[i].chk_aop,
                          tbl[i].rn, tbl[i].rm, tbl[i].rd, tbl[i].imm, tbl[i].chk_imm);
        end
        in_valid = 1'b0;
        tick();
        check_val("idle.valid", 64'(ov1), 64'd0);

        // LOAD_SHADOW=2: two bubbles.
        reset = 1'b1; tick(); reset = 1'b0;
        in_valid = 1'b1; instr = I_LDUR;
        tick();
        check_val("ls2.ldur.valid", 64'(ov2), 64'd1);
        check_val("ls2.ldur.rd", 64'(rd2), 64'd3);
        instr = I_ADDS; #1;
        check_val("ls2.stall0.in_ready", 64'(ir2), 64'd0);
        tick();
        check_val("ls2.bubble1.valid", 64'(ov2), 64'd0);
        check_val("ls2.stall1.in_ready", 64'(ir2), 64'd0);
        tick();
        check_val("ls2.bubble2.valid", 64'(ov2), 64'd0);
        check_val("ls2.go.in_ready", 64'(ir2), 64'd1);
        tick();
        check_val("ls2.adds.valid", 64'(ov2), 64'd1);
        check_val("ls2.adds.rn", 64'(rn2), 64'd3);
        check_val("ls2.adds.rm", 64'(rm2), 64'd5);
        check_val("ls2.adds.set_flags", 64'(sf2), 64'd1);

        // Flush while a dependent is stalled behind a load.
        reset = 1'b1; tick(); reset = 1'b0;
        instr = I_LDUR;
        tick();
        check_val("fl.ldur.valid", 64'(ov2), 64'd1);
        instr = I_ADDS; flush = 1'b1; #1;
        check_val("fl.in_ready1", 64'(ir1), 64'd0);
        check_val("fl.in_ready2", 64'(ir2), 64'd0);
        tick();
        flush = 1'b0;
        check_val("fl.valid1", 64'(ov1), 64'd0);
        check_val("fl.valid2", 64'(ov2), 64'd0);
        #1;
        check_val("fl.re.in_ready2", 64'(ir2), 64'd1);
        check_val("fl.re.in_ready1", 64'(ir1), 64'd1);
        tick();
        check_val("fl.adds.valid2", 64'(ov2), 64'd1);
        check_val("fl.adds.rn2", 64'(rn2), 64'd3);

        // Flush kills a held bundle.
        instr = I_ADDI;
        tick();
        out_ready = 1'b0; flush = 1'b1;
        tick();
        check_val("flhold.valid", 64'(ov1), 64'd0);
        flush = 1'b0; out_ready = 1'b1;

        // Reset mid-stream (with flush also high) restores reset values.
        instr = I_BL;
        tick();
        check_val("mid.bl.valid", 64'(ov1), 64'd1);
        reset = 1'b1; flush = 1'b1; instr = I_ADDI;
        tick();
        check_bundle1("midrst", 1'b0, 11'd0, 3'b000, 1'b1, 5'd31, 5'd31, 5'd31, 64'd0, 1'b1);
        check_val("midrst.valid2", 64'(ov2), 64'd0);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
